// File: rtl/glitch_window_ctrl.sv
// Measurement-window sequencer for the glitch detector: clears it, lets it settle,
// then counts detector increments over a programmed number of cycles.
module glitch_window_ctrl #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic [CNT_W-1:0] det_count,
    output logic             det_rst_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             saturated,
    output logic             over_thresh
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               phase;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   thr_q;
    logic [CNT_W-1:0]   det_count_q;
    logic [CNT_W-1:0]   evt_cnt;
    logic [CNT_W-1:0]   evt_next;
    logic               sat_flag;
    logic               sat_next;
    logic               accept;
    logic               finish_win;

    assign accept     = (state == IDLE) && start && !abort;
    assign finish_win = (state == RUN) && (next_state == DONE);
    assign busy       = (state == CLEAR) || (state == SETTLE) || (state == RUN);
    assign done       = (state == DONE);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CLEAR;
            CLEAR:   if (abort) next_state = IDLE;
                     else if (phase) next_state = SETTLE;
            SETTLE:  if (abort) next_state = IDLE;
                     else if (phase) next_state = RUN;
            RUN:     if (abort) next_state = IDLE;
                     else if (win_cnt == WIN_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The detector steps by at most one per cycle, so any change is exactly one event.
    always_comb begin
        evt_next = evt_cnt;
        sat_next = sat_flag;
        if (det_count != det_count_q) begin
            if (evt_cnt == '1) sat_next = 1'b1;
            else               evt_next = evt_cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= 1'b0;
            win_cnt     <= '0;
            thr_q       <= '0;
            det_count_q <= '0;
            evt_cnt     <= '0;
            sat_flag    <= 1'b0;
            det_rst_n   <= 1'b1;
            result      <= '0;
            saturated   <= 1'b0;
            over_thresh <= 1'b0;
        end else begin
            state       <= next_state;
            det_count_q <= det_count;
            det_rst_n   <= (next_state != CLEAR);
            phase       <= ((state == CLEAR || state == SETTLE) && next_state == state) ? ~phase : 1'b0;

            if (accept) begin
                win_cnt  <= (win_len == '0) ? WIN_W'(1) : win_len;
                thr_q    <= threshold;
                evt_cnt  <= '0;
                sat_flag <= 1'b0;
            end else if (state == RUN) begin
                win_cnt  <= win_cnt - WIN_W'(1);
                evt_cnt  <= evt_next;
                sat_flag <= sat_next;
            end

            // Results include a change seen in the final RUN cycle.
            if (finish_win) begin
                result      <= evt_next;
                saturated   <= sat_next;
                over_thresh <= (evt_next >= thr_q);
            end
        end
    end

endmodule

// File: tb/tb_glitch_window_ctrl.sv
// Directed bench for glitch_window_ctrl: window timing, counting, saturation,
// abort, ignored starts and asynchronous reset.
module tb_glitch_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic [7:0]  threshold;
    logic [7:0]  det_count;
    logic        det_rst_n;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic        saturated;
    logic        over_thresh;

    int passed = 0;
    int total  = 0;

    glitch_window_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .win_len     (win_len),
        .threshold   (threshold),
        .det_count   (det_count),
        .det_rst_n   (det_rst_n),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .saturated   (saturated),
        .over_thresh (over_thresh)
    );

    always #5 clk = ~clk;

    // Expected {busy, done, det_rst_n} in cycle T+k for a window of n RUN cycles.
    function automatic logic [2:0] exp_ctl(int k, int n);
        logic b, d, r;
        b = (k >= 1) && (k <= 4 + n);
        d = (k == 5 + n);
        r = !((k == 1) || (k == 2));
        return {b, d, r};
    endfunction

    // Present a start at this negedge; returns at the negedge of cycle T+1.
    task automatic begin_start(input logic [15:0] wl, input logic [7:0] th);
        start     = 1'b1;
        win_len   = wl;
        threshold = th;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, det_rst_n, result, saturated, over_thresh} !== {3'b001, 8'd0, 2'b00})
            $display("FAIL reset_values got %b exp %b",
                     {busy, done, det_rst_n, result, saturated, over_thresh}, {3'b001, 8'd0, 2'b00});
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            det_count = det_count + 8'd3;
            @(negedge clk);
            total++;
            if ({busy, done, det_rst_n, result} !== {3'b001, 8'd0})
                $display("FAIL idle_hold k=%0d got %b exp %b", k, {busy, done, det_rst_n, result}, {3'b001, 8'd0});
            else passed++;
        end
    endtask

    task automatic test_basic;
        begin_start(16'd10, 8'd3);
        for (int k = 1; k <= 16; k++) begin
            total++;
            if ({busy, done, det_rst_n} !== exp_ctl(k, 10))
                $display("FAIL basic_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, exp_ctl(k, 10));
            else passed++;
            if (k == 15) begin
                total++;
                if ({result, over_thresh, saturated} !== {8'd4, 1'b1, 1'b0})
                    $display("FAIL basic_result got %0d/%b/%b exp 4/1/0", result, over_thresh, saturated);
                else passed++;
            end
            if (k == 3 || k == 4 || k == 5 || k == 7 || k == 9 || k == 14)
                det_count = det_count + 8'd1;
            @(negedge clk);
        end
    endtask

    task automatic test_abort;
        begin_start(16'd20, 8'd3);
        for (int k = 1; k <= 9; k++) begin
            logic [2:0] e;
            e = (k <= 7) ? exp_ctl(k, 20) : 3'b001;
            total++;
            if ({busy, done, det_rst_n} !== e)
                $display("FAIL abort_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, e);
            else passed++;
            if (k == 5 || k == 6) det_count = det_count + 8'd1;
            if (k == 7) abort = 1'b1;
            if (k == 8) begin
                abort = 1'b0;
                total++;
                if ({result, over_thresh, saturated} !== {8'd4, 1'b1, 1'b0})
                    $display("FAIL abort_result_kept got %0d/%b/%b exp 4/1/0", result, over_thresh, saturated);
                else passed++;
            end
            if (k == 9) begin
                start     = 1'b1;
                win_len   = 16'd2;
                threshold = 8'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if ({busy, done, det_rst_n} !== exp_ctl(k, 2))
                $display("FAIL restart_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, exp_ctl(k, 2));
            else passed++;
            if (k == 7) begin
                total++;
                if ({result, over_thresh, saturated} !== {8'd0, 1'b1, 1'b0})
                    $display("FAIL restart_thr0 got %0d/%b/%b exp 0/1/0", result, over_thresh, saturated);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap;
        det_count = 8'd250;
        begin_start(16'd300, 8'd255);
        for (int k = 1; k <= 306; k++) begin
            total++;
            if ({busy, done, det_rst_n} !== exp_ctl(k, 300))
                $display("FAIL wrap_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, exp_ctl(k, 300));
            else passed++;
            if (k == 305) begin
                total++;
                if ({result, saturated, over_thresh} !== {8'd255, 1'b1, 1'b1})
                    $display("FAIL wrap_result got %0d/%b/%b exp 255/1/1", result, saturated, over_thresh);
                else passed++;
            end
            det_count = det_count + 8'd1;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_len;
        begin_start(16'd0, 8'd1);
        for (int k = 1; k <= 7; k++) begin
            total++;
            if ({busy, done, det_rst_n} !== exp_ctl(k, 1))
                $display("FAIL zero_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, exp_ctl(k, 1));
            else passed++;
            if (k == 6) begin
                total++;
                if ({result, saturated, over_thresh} !== {8'd1, 1'b0, 1'b1})
                    $display("FAIL zero_result got %0d/%b/%b exp 1/0/1", result, saturated, over_thresh);
                else passed++;
            end
            if (k == 4 || k == 5 || k == 6) det_count = det_count + 8'd1;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        begin_start(16'd3, 8'd5);
        for (int k = 1; k <= 11; k++) begin
            total++;
            if ({busy, done, det_rst_n} !== exp_ctl(k, 3))
                $display("FAIL b2b_ctl k=%0d got %b exp %b", k, {busy, done, det_rst_n}, exp_ctl(k, 3));
            else passed++;
            if (k == 8) begin
                total++;
                if ({result, saturated, over_thresh} !== {8'd1, 1'b0, 1'b0})
                    $display("FAIL b2b_result got %0d/%b/%b exp 1/0/0", result, saturated, over_thresh);
                else passed++;
            end
            start = (k == 6) || (k == 8);
            if (k == 6) win_len = 16'd1;
            if (k == 7) det_count = det_count + 8'd1;
            @(negedge clk);
        end
        start = 1'b1;
        abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done, det_rst_n} !== 3'b001)
                $display("FAIL start_abort_idle k=%0d got %b exp 001", k, {busy, done, det_rst_n});
            else passed++;
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        begin_start(16'd5, 8'd0);
        @(negedge clk);
        total++;
        if ({busy, det_rst_n, result} !== {2'b10, 8'd1})
            $display("FAIL midrst_pre got %b exp %b", {busy, det_rst_n, result}, {2'b10, 8'd1});
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, det_rst_n, result, saturated, over_thresh} !== {3'b001, 8'd0, 2'b00})
            $display("FAIL midrst_async got %b exp %b",
                     {busy, done, det_rst_n, result, saturated, over_thresh}, {3'b001, 8'd0, 2'b00});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done, det_rst_n} !== 3'b001)
                $display("FAIL midrst_idle k=%0d got %b exp 001", k, {busy, done, det_rst_n});
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        win_len   = 16'd0;
        threshold = 8'd0;
        det_count = 8'd0;
        test_reset();
        test_basic();
        test_abort();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/glitch_window_ctrl.md
Name: glitch_window_ctrl

Overview:
- Sequences a measurement window around the 4-bit glitch detector, which has an 8-bit free-running, wrapping glitch counter and an active-low reset.
- Per measurement: clears the detector, discards its start-up samples, then counts detector increments for a programmed number of cycles.
- Reports a saturating glitch count plus a threshold flag to the host/readout logic.

Parameters:
- WIN_W, 16, width of the window-length input and internal window counter.
- CNT_W, 8, width of the detector count input and of result/threshold.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a measurement; honoured only in IDLE.
- abort  input  1  cancels a measurement in progress.
- win_len  input  WIN_W  window length in cycles; sampled on accepted start.
- threshold  input  CNT_W  alarm threshold; sampled on accepted start.
- det_count  input  CNT_W  detector glitch counter output.
- det_rst_n  output  1  active-low clear driven to the detector.
- busy  output  1  high in CLEAR, SETTLE and RUN.
- done  output  1  one-cycle pulse, high in the DONE state.
- result  output  CNT_W  glitch count of the last completed window.
- saturated  output  1  last window's count hit all-ones.
- over_thresh  output  1  last completed result >= sampled threshold.

Behaviour:
- Reset (async, rst=1): state IDLE; det_rst_n=1; busy=0; done=0; result=0; saturated=0; over_thresh=0; internal counters and det_count_q cleared.
- det_count_q register: captures det_count every cycle in all states.
- States and transitions:
  - IDLE: start=1 and abort=0 at edge T -> CLEAR. win_len and threshold latch at T. A win_len of 0 is treated as 1.
  - CLEAR: 2 cycles (T+1, T+2). det_rst_n=0, registered and decoded from state -> SETTLE.
  - SETTLE: 2 cycles (T+3, T+4). det_rst_n=1. No counting, which discards detector artefacts from its zeroed history -> RUN.
  - RUN: exactly N cycles (T+5 .. T+4+N), N = latched window length. In each RUN cycle, det_count != det_count_q increments the event counter by 1, since the detector increments by at most 1 per cycle. The event counter saturates at 2^CNT_W-1; saturated sets if an increment is requested at max. After the Nth RUN cycle -> DONE.
  - DONE: exactly 1 cycle at T+5+N. done=1 and busy=0. result, saturated and over_thresh are updated at the edge entering DONE and hold until the next completed window. -> IDLE.
- Latency: start sampled at edge T -> done high during cycle T+5+N. Total busy cycles = 4+N.
- A change visible on det_count in the last RUN cycle is counted. Changes during CLEAR/SETTLE are never counted.
- Detector wrap (255->0) is seen as a change and counted; result is therefore independent of detector wrap.
- start while busy or in DONE: ignored, no queueing.
- abort=1 in CLEAR/SETTLE/RUN/DONE -> IDLE next edge. det_rst_n returns to 1; no done pulse in that case (a DONE-cycle abort does not suppress the done already showing). result/saturated/over_thresh are unchanged unless already updated entering DONE.
- start and abort together in IDLE: abort wins, stay IDLE.
- rst asserted mid-measurement: immediate return to reset values, including result=0.
- over_thresh with threshold=0: always 1 after any completed window.

Test Plan:
- Reset then idle: det_count toggling, no start -> busy=0, done=0, det_rst_n=1, result=0 throughout.
- win_len=10, threshold=3, det_count stepping +1 on 4 separate RUN cycles (plus 2 steps during SETTLE) -> det_rst_n low exactly cycles T+1..T+2; done at T+15; result=4; over_thresh=1; saturated=0.
- win_len=300, det_count incrementing every cycle through wrap 255->0 -> result=255; saturated=1; done at T+305.
- win_len=0 -> treated as 1; one change in that RUN cycle -> result=1; done at T+6.
- abort at T+7 during a win_len=20 window, with prior result=4 -> IDLE at T+8; no done pulse; result stays 4; a second start at T+9 is accepted.
- start pulsed again during RUN, and start+abort together in IDLE -> both ignored; busy/done timing unchanged for the first run; IDLE persists in the second case.
